pim_ctrl_unit: RTL and testbench



---
 rtl/pim_ctrl_pkg.sv | 31 +++
 rtl/pim_wl_counter.sv | 28 ++
 rtl/pim_ctrl_unit.sv | 173 +++++++++++++++++
 tb/tb_pim_ctrl_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pim_ctrl_pkg.sv
// pim_ctrl_pkg: types and constants shared by the PIM sequencer and its
// neighbours. The default address map also serves the DMA engine.
//   pim_state_e : sequencer FSM states
//   CTRL_*      : bit positions inside the CTRL register
//   DEF_PIM_*   : default memory map of the PIM slave port
package pim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } pim_state_e;

  // CTRL register layout (write and read views share the low fields)
  localparam int CTRL_MASK_LSB    = 0;
  localparam int CTRL_SEL_LSB     = 4;
  localparam int CTRL_SEL_W       = 2;
  localparam int CTRL_START_BIT   = 8;
  localparam int CTRL_WL_CLR_BIT  = 9;
  localparam int CTRL_ERR_CLR_BIT = 10;
  localparam int CTRL_BUSY_BIT    = 10;
  localparam int CTRL_DONE_BIT    = 11;
  localparam int CTRL_ERR_BIT     = 12;

  localparam logic [31:0] DEF_PIM_CTRL         = 32'h4000_0010;
  localparam logic [31:0] DEF_PIM_R            = 32'h4000_0020;
  localparam logic [31:0] DEF_PIM_W_WEIGHT     = 32'h4000_0040;
  localparam logic [31:0] DEF_PIM_W_ACTIVATION = 32'h4000_0080;

endpackage

// File: rtl/pim_wl_counter.sv
// pim_wl_counter: wordline pointer for weight programming.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : reset pointer to 0 (wins over i_inc)
//   i_inc          : advance pointer by one, wrapping at 2^WL_ADDR_W
//   o_ptr          : current wordline pointer
module pim_wl_counter
  import pim_ctrl_pkg::*;
#(
  parameter int WL_ADDR_W = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_inc,
  output logic [WL_ADDR_W-1:0] o_ptr
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ptr <= '0;
    end else if (i_clr) begin
      o_ptr <= '0;
    end else if (i_inc) begin
      o_ptr <= o_ptr + WL_ADDR_W'(1);  // natural wrap 63 -> 0
    end
  end

endmodule

// File: rtl/pim_ctrl_unit.sv
// pim_ctrl_unit: memory-mapped sequencer between the IDS bus PIM slave port
// and the PIM macros. Bus writes become weight/activation strobes; a start
// runs a fixed-latency compute and captures per-macro results.
//   i_pim_*         : bus slave port (addr, write, read, size, din, dout)
//   o_weight_out_en : one-hot weight write strobe, with o_wl_addr/o_cim_data
//   o_act_out_en    : activation drive strobe (snapshotted mask, DRIVE only)
//   o_act_out_data  : last accepted activation word
//   i_result_in     : macro results, macro k at [k*RESULT_W +: RESULT_W]
//   o_pim_busy      : FSM not idle
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | accepts weight/activation writes and start
// ST_DRIVE   | one cycle of o_act_out_en = snapshotted mask
// ST_WAIT    | COMP_LAT cycles of macro compute latency
// ST_CAPTURE | latch all results, set done
module pim_ctrl_unit
  import pim_ctrl_pkg::*;
#(
  parameter int              XLEN             = 32,
  parameter int              N_MACRO          = 4,
  parameter int              WL_ADDR_W        = 6,
  parameter int              RESULT_W         = 16,
  parameter int              COMP_LAT         = 8,
  parameter logic [XLEN-1:0] PIM_CTRL         = DEF_PIM_CTRL,
  parameter logic [XLEN-1:0] PIM_R            = DEF_PIM_R,
  parameter logic [XLEN-1:0] PIM_W_WEIGHT     = DEF_PIM_W_WEIGHT,
  parameter logic [XLEN-1:0] PIM_W_ACTIVATION = DEF_PIM_W_ACTIVATION
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [XLEN-1:0]              i_pim_addr,
  input  logic                         i_pim_write,
  input  logic                         i_pim_read,
  input  logic [3:0]                   i_pim_size,
  input  logic [XLEN-1:0]              i_pim_din,
  output logic [XLEN-1:0]              o_pim_dout,
  output logic [N_MACRO-1:0]           o_weight_out_en,
  output logic [WL_ADDR_W-1:0]         o_wl_addr,
  output logic [XLEN-1:0]              o_cim_data,
  output logic [N_MACRO-1:0]           o_act_out_en,
  output logic [XLEN-1:0]              o_act_out_data,
  input  logic [N_MACRO*RESULT_W-1:0]  i_result_in,
  output logic                         o_pim_busy
);

  localparam int CNT_W = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;

  pim_state_e state_q, state_nxt;

  logic [N_MACRO-1:0]                mask_q, mask_snap;
  logic [CTRL_SEL_W-1:0]             sel_q;
  logic                              done_q, err_q;
  logic [N_MACRO-1:0][RESULT_W-1:0]  result_q;
  logic [CNT_W-1:0]                  lat_cnt;
  logic [WL_ADDR_W-1:0]              wl_ptr;
  logic [XLEN-1:0]                   rd_data, ctrl_rd;

  // Partial-size writes are ignored everywhere, including the busy error.
  logic wr_ok, ctrl_wr, weight_wr, act_wr, start_req, is_idle;
  logic weight_acc, act_acc, start_go, err_set, wl_clr, lat_done;

  assign wr_ok      = i_pim_write && (i_pim_size == 4'b1111);
  assign ctrl_wr    = wr_ok && (i_pim_addr == PIM_CTRL);
  assign weight_wr  = wr_ok && (i_pim_addr == PIM_W_WEIGHT);
  assign act_wr     = wr_ok && (i_pim_addr == PIM_W_ACTIVATION);
  assign start_req  = ctrl_wr && i_pim_din[CTRL_START_BIT];
  assign wl_clr     = ctrl_wr && i_pim_din[CTRL_WL_CLR_BIT];
  assign is_idle    = (state_q == ST_IDLE);
  assign weight_acc = weight_wr && is_idle;
  assign act_acc    = act_wr && is_idle;
  assign start_go   = start_req && is_idle;
  assign err_set    = !is_idle && (weight_wr || act_wr || start_req);
  assign lat_done   = (lat_cnt == '0);

  pim_wl_counter #(.WL_ADDR_W(WL_ADDR_W)) u_wl_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (wl_clr),
    .i_inc   (weight_acc),
    .o_ptr   (wl_ptr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt    = state_q;
    o_act_out_en = '0;
    o_pim_busy   = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:    if (start_go) state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        o_act_out_en = mask_snap;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT:    if (lat_done) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Down-counter loaded in DRIVE so WAIT lasts exactly COMP_LAT cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_cnt <= '0;
    end else if (state_q == ST_DRIVE) begin
      lat_cnt <= CNT_W'(COMP_LAT - 1);
    end else if (state_q == ST_WAIT && !lat_done) begin
      lat_cnt <= lat_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_MASK_LSB +: N_MACRO]   = mask_q;
    ctrl_rd[CTRL_SEL_LSB +: CTRL_SEL_W] = sel_q;
    ctrl_rd[CTRL_BUSY_BIT]              = o_pim_busy;
    ctrl_rd[CTRL_DONE_BIT]              = done_q;
    ctrl_rd[CTRL_ERR_BIT]               = err_q;
  end

  always_comb begin
    rd_data = '0;
    if (i_pim_addr == PIM_CTRL) rd_data = ctrl_rd;
    for (int k = 0; k < N_MACRO; k++) begin
      if (i_pim_addr == PIM_R + XLEN'(4 * k)) rd_data = XLEN'(result_q[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_q          <= '0;
      mask_snap       <= '0;
      sel_q           <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      result_q        <= '0;
      o_weight_out_en <= '0;
      o_wl_addr       <= '0;
      o_cim_data      <= '0;
      o_act_out_data  <= '0;
      o_pim_dout      <= '0;
    end else begin
      if (ctrl_wr) begin
        mask_q <= i_pim_din[CTRL_MASK_LSB +: N_MACRO];
        sel_q  <= i_pim_din[CTRL_SEL_LSB +: CTRL_SEL_W];
      end
      if (start_go) begin
        mask_snap <= i_pim_din[CTRL_MASK_LSB +: N_MACRO];
        done_q    <= 1'b0;
      end
      if (state_q == ST_CAPTURE) begin
        result_q <= i_result_in;
        done_q   <= 1'b1;
      end
      // A fresh violation outranks a clear arriving in the same write.
      if (err_set)                                   err_q <= 1'b1;
      else if (ctrl_wr && i_pim_din[CTRL_ERR_CLR_BIT]) err_q <= 1'b0;

      o_weight_out_en <= weight_acc ? (N_MACRO'(1) << sel_q) : '0;
      if (weight_acc) begin
        o_wl_addr  <= wl_ptr;
        o_cim_data <= i_pim_din;
      end
      if (act_acc)    o_act_out_data <= i_pim_din;
      if (i_pim_read) o_pim_dout     <= rd_data;
    end
  end

endmodule

// File: tb/tb_pim_ctrl_unit.sv
// tb_pim_ctrl_unit: directed bench for pim_ctrl_unit. Bus reads push their
// expected value to a scoreboard queue; it is popped when dout is valid.
module tb_pim_ctrl_unit;

  localparam logic [31:0] A_CTRL = 32'h4000_0010;
  localparam logic [31:0] A_R    = 32'h4000_0020;
  localparam logic [31:0] A_W    = 32'h4000_0040;
  localparam logic [31:0] A_ACT  = 32'h4000_0080;

  logic        clk, rst_n;
  logic [31:0] pim_addr, pim_din, pim_dout;
  logic        pim_write, pim_read;
  logic [3:0]  pim_size;
  logic [3:0]  weight_en, act_en;
  logic [5:0]  wl_addr;
  logic [31:0] cim_data, act_data;
  logic [63:0] result_in;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  pim_ctrl_unit dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pim_addr      (pim_addr),
    .i_pim_write     (pim_write),
    .i_pim_read      (pim_read),
    .i_pim_size      (pim_size),
    .i_pim_din       (pim_din),
    .o_pim_dout      (pim_dout),
    .o_weight_out_en (weight_en),
    .o_wl_addr       (wl_addr),
    .o_cim_data      (cim_data),
    .o_act_out_en    (act_en),
    .o_act_out_data  (act_data),
    .i_result_in     (result_in),
    .o_pim_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive at a negedge; returns at the next negedge, when registered
  // outputs of the access are visible.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] size);
    pim_addr = addr; pim_din = data; pim_size = size; pim_write = 1'b1;
    @(negedge clk);
    pim_write = 1'b0; pim_size = 4'hF;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    pim_addr = addr; pim_read = 1'b1;
    exp_q.push_back(exp); tag_q.push_back(tag);
    @(negedge clk);
    pim_read = 1'b0;
    check(tag_q.pop_front(), pim_dout, exp_q.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"},  32'(weight_en), 32'h0);
    check({tag, "_wl"},   32'(wl_addr),   32'h0);
    check({tag, "_cim"},  cim_data,       32'h0);
    check({tag, "_aen"},  32'(act_en),    32'h0);
    check({tag, "_act"},  act_data,       32'h0);
    check({tag, "_dout"}, pim_dout,       32'h0);
    check({tag, "_busy"}, 32'(busy),      32'h0);
  endtask

  initial begin
    rst_n = 1'b0; pim_addr = '0; pim_din = '0; pim_write = 1'b0; pim_read = 1'b0;
    pim_size = 4'hF; result_in = '0;
    repeat (3) tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();
    bus_read(A_CTRL, 32'h0, "rst_ctrl");

    // Weight stream to macro 2 with pointer wrap
    bus_write(A_CTRL, 32'h20, 4'hF);
    for (int i = 0; i < 65; i++) begin
      bus_write(A_W, 32'(i), 4'hF);
      check("ws_wen", 32'(weight_en), 32'h4);
      check("ws_wl",  32'(wl_addr),   32'(i % 64));
      check("ws_cim", cim_data,       32'(i));
    end
    tick();
    check("ws_wen_single", 32'(weight_en), 32'h0);

    // Compute with mask 1011
    bus_write(A_CTRL, 32'h2B, 4'hF);
    bus_write(A_ACT, 32'hA5A5_0001, 4'hF);
    check("act_data", act_data, 32'hA5A5_0001);
    result_in = {16'h4, 16'h3, 16'h2, 16'h1};
    bus_write(A_CTRL, 32'h12B, 4'hF);
    check("cmp_aen_drive", 32'(act_en), 32'hB);
    check("cmp_busy_t1",   32'(busy),   32'h1);
    for (int c = 2; c <= 11; c++) begin
      tick();
      check("cmp_busy", 32'(busy), (c <= 10) ? 32'h1 : 32'h0);
      check("cmp_aen_off", 32'(act_en), 32'h0);
    end
    result_in = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
    for (int k = 0; k < 4; k++) bus_read(A_R + 32'(4 * k), 32'(k + 1), "cmp_res");
    bus_read(A_CTRL, 32'h82B, "cmp_ctrl_done");

    // Busy violations during WAIT
    result_in = {16'h8, 16'h7, 16'h6, 16'h5};
    bus_write(A_CTRL, 32'h12B, 4'hF);
    tick();
    bus_write(A_W, 32'h5555_5555, 4'hF);
    check("bv_wen", 32'(weight_en), 32'h0);
    bus_write(A_CTRL, 32'h12B, 4'hF);
    check("bv_busy_t4", 32'(busy), 32'h1);
    for (int c = 5; c <= 11; c++) begin
      tick();
      check("bv_busy", 32'(busy), (c <= 10) ? 32'h1 : 32'h0);
    end
    bus_read(A_CTRL, 32'h182B, "bv_ctrl_err");
    bus_read(A_R + 32'd4, 32'h6, "bv_res1");
    bus_write(A_CTRL, 32'h42B, 4'hF);
    bus_read(A_CTRL, 32'h82B, "bv_err_clr");

    // Partial-size activation write is ignored
    bus_write(A_ACT, 32'h1234_5678, 4'b0011);
    check("psize_act", act_data, 32'hA5A5_0001);

    // Dropped busy weight write must not have moved the pointer (65 -> 1)
    bus_write(A_W, 32'h11, 4'hF);
    check("ptr_after_bv", 32'(wl_addr), 32'h1);

    // Combined wl_clr + start
    bus_write(A_CTRL, 32'h32B, 4'hF);
    check("comb_busy", 32'(busy), 32'h1);
    for (int c = 2; c <= 11; c++) tick();
    check("comb_idle", 32'(busy), 32'h0);
    bus_read(A_CTRL, 32'h82B, "comb_done");
    bus_write(A_W, 32'h77, 4'hF);
    check("comb_wl",  32'(wl_addr),   32'h0);
    check("comb_wen", 32'(weight_en), 32'h4);
    bus_write(A_W, 32'h88, 4'hF);
    check("comb_wl_next", 32'(wl_addr), 32'h1);

    // Same-cycle read and write of CTRL returns the old value
    pim_addr = A_CTRL; pim_din = 32'h1F; pim_write = 1'b1; pim_read = 1'b1;
    exp_q.push_back(32'h82B); tag_q.push_back("rw_same_cycle");
    tick();
    pim_write = 1'b0; pim_read = 1'b0;
    check(tag_q.pop_front(), pim_dout, exp_q.pop_front());
    bus_read(A_CTRL, 32'h81F, "rw_after");
    bus_read(32'h4000_0030, 32'h0, "unmapped");
    bus_read(A_W, 32'h0, "wport_read");

    // Reset asserted mid-WAIT
    bus_write(A_CTRL, 32'h11F, 4'hF);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("rst_mid_idle", 32'(busy), 32'h0);
    bus_read(A_CTRL, 32'h0, "rst_mid_ctrl");
    bus_read(A_R, 32'h0, "rst_mid_res");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
